// File: rtl/ts_packet_buffer.sv
// ts_packet_buffer: sync-aligned TS packet slot buffer with whole-packet playout.
// Optional build macro SYNC_BYTE_CHECK_EN: P_SYNC is honoured only on a 0x47 byte.
module ts_packet_buffer #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned PKT_LEN    = 188,
  parameter int unsigned DEPTH_PKTS = 4,
  parameter int unsigned LOCK_CNT   = 3,
  parameter int unsigned UNLOCK_CNT = 3
) (
  input  logic                            SYS_CLK,
  input  logic                            RST,
  input  logic [DATA_W-1:0]               DATA,
  input  logic                            D_VALID,
  input  logic                            P_SYNC,
  input  logic                            GIVE_ME_ONE_PACKET,
  output logic [DATA_W-1:0]               DATA_OUT,
  output logic                            DATA_OUT_VALID,
  output logic                            PACKET_START_OUT,
  output logic                            GOT_FULL_PACKET,
  output logic [$clog2(DEPTH_PKTS+1)-1:0] PACKETS_STORED,
  output logic                            SYNC_LOCKED,
  output logic                            OVERFLOW
);
  localparam int unsigned BC_W  = $clog2(PKT_LEN + 1);
  localparam int unsigned OFF_W = $clog2(PKT_LEN);
  localparam int unsigned PTR_W = $clog2(DEPTH_PKTS);
  localparam int unsigned CNT_W = $clog2(DEPTH_PKTS + 1);
  localparam int unsigned LC_W  = $clog2(LOCK_CNT + 1);
  localparam int unsigned UC_W  = $clog2(UNLOCK_CNT + 1);

  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} lock_t;
  typedef enum logic {IDLE, READ} rd_t;

  lock_t             lock_st, lock_nx;
  logic [LC_W-1:0]   good_cnt, good_nx;
  logic [UC_W-1:0]   bad_cnt, bad_nx;
  logic [BC_W-1:0]   bcnt;
  logic              sync_c, on_time_c, early_c, late_c, err_c;
  logic              store_ok_c, flush_c;
  logic              wr_active, wr_en_c, admit_c, drop_c, commit_c;
  logic [OFF_W-1:0]  wr_off_c, rd_off;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  stored_nx;
  rd_t               rd_st, rd_nx;
  logic              rd_issue_c, rd_last_c;
  logic [DATA_W-1:0] mem [DEPTH_PKTS][PKT_LEN];

`ifdef SYNC_BYTE_CHECK_EN
  assign sync_c = D_VALID && P_SYNC && (DATA[7:0] == 8'h47);
`else
  assign sync_c = D_VALID && P_SYNC;
`endif
  assign on_time_c = sync_c && (bcnt == BC_W'(PKT_LEN));
  assign early_c   = sync_c && (bcnt != '0) && (bcnt < BC_W'(PKT_LEN));
  assign late_c    = D_VALID && !sync_c && (bcnt == BC_W'(PKT_LEN));
  assign err_c     = early_c || late_c;

  // Lock FSM state register (with its good/bad sync counters)
  always_ff @(posedge SYS_CLK or negedge RST) begin
    if (!RST) begin
      lock_st     <= HUNT;
      good_cnt    <= '0;
      bad_cnt     <= '0;
      SYNC_LOCKED <= 1'b0;
    end else begin
      lock_st     <= lock_nx;
      good_cnt    <= good_nx;
      bad_cnt     <= bad_nx;
      SYNC_LOCKED <= (lock_nx == LOCKED);
    end
  end

  always_comb begin
    lock_nx = lock_st;
    good_nx = good_cnt;
    bad_nx  = bad_cnt;
    case (lock_st)
      HUNT: if (sync_c) begin
        lock_nx = VERIFY;
        good_nx = '0;
      end
      VERIFY: if (err_c) begin
        lock_nx = HUNT;
      end else if (on_time_c) begin
        if (good_cnt == LC_W'(LOCK_CNT - 1)) begin
          lock_nx = LOCKED;
          bad_nx  = '0;
        end else begin
          good_nx = good_cnt + 1'b1;
        end
      end
      LOCKED: if (err_c) begin
        if (bad_cnt == UC_W'(UNLOCK_CNT - 1)) lock_nx = HUNT;
        else bad_nx = bad_cnt + 1'b1;
      end else if (on_time_c) begin
        bad_nx = '0;
      end
      default: lock_nx = HUNT;
    endcase
  end

  // Entering HUNT flushes every buffer and playout resource
  always_comb begin
    store_ok_c = (lock_nx != HUNT);
    flush_c    = (lock_st != HUNT) && (lock_nx == HUNT);
  end

  always_ff @(posedge SYS_CLK or negedge RST) begin
    if (!RST) begin
      bcnt <= '0;
    end else if (D_VALID) begin
      if (sync_c)                         bcnt <= BC_W'(1);
      else if (bcnt == BC_W'(PKT_LEN))    bcnt <= '0;
      else if (bcnt != '0)                bcnt <= bcnt + 1'b1;
    end
  end

  // Slot admission is decided on the sync byte; later bytes follow bcnt
  always_comb begin
    wr_en_c  = 1'b0;
    wr_off_c = '0;
    admit_c  = 1'b0;
    drop_c   = 1'b0;
    if (sync_c && store_ok_c) begin
      if (PACKETS_STORED == CNT_W'(DEPTH_PKTS)) begin
        drop_c = 1'b1;
      end else begin
        admit_c = 1'b1;
        wr_en_c = 1'b1;
      end
    end else if (D_VALID && !sync_c && wr_active && (bcnt != '0) && (bcnt < BC_W'(PKT_LEN))) begin
      wr_en_c  = 1'b1;
      wr_off_c = OFF_W'(bcnt);
    end
    commit_c = wr_en_c && !flush_c && (wr_off_c == OFF_W'(PKT_LEN - 1));
  end

  always_ff @(posedge SYS_CLK) begin
    if (wr_en_c) mem[wr_ptr][wr_off_c] <= DATA;
  end

  // Read FSM state register
  always_ff @(posedge SYS_CLK or negedge RST) begin
    if (!RST) rd_st <= IDLE;
    else      rd_st <= rd_nx;
  end

  always_comb begin
    rd_nx = rd_st;
    case (rd_st)
      IDLE:    if (GIVE_ME_ONE_PACKET && (PACKETS_STORED != '0)) rd_nx = READ;
      READ:    if (rd_off == OFF_W'(PKT_LEN - 1)) rd_nx = IDLE;
      default: rd_nx = IDLE;
    endcase
    if (flush_c) rd_nx = IDLE;
  end

  always_comb begin
    rd_issue_c = (rd_st == READ) && !flush_c;
    rd_last_c  = rd_issue_c && (rd_off == OFF_W'(PKT_LEN - 1));
  end

  always_comb begin
    stored_nx = PACKETS_STORED;
    if (flush_c)                    stored_nx = '0;
    else if (commit_c && !rd_last_c) stored_nx = PACKETS_STORED + 1'b1;
    else if (!commit_c && rd_last_c) stored_nx = PACKETS_STORED - 1'b1;
  end

  always_ff @(posedge SYS_CLK or negedge RST) begin
    if (!RST) begin
      wr_active <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      rd_off    <= '0;
    end else if (flush_c) begin
      wr_active <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      rd_off    <= '0;
    end else begin
      if (sync_c)        wr_active <= admit_c;
      else if (commit_c) wr_active <= 1'b0;
      if (commit_c)
        wr_ptr <= (wr_ptr == PTR_W'(DEPTH_PKTS - 1)) ? '0 : wr_ptr + 1'b1;
      if (rd_issue_c)
        rd_off <= rd_last_c ? '0 : rd_off + 1'b1;
      if (rd_last_c)
        rd_ptr <= (rd_ptr == PTR_W'(DEPTH_PKTS - 1)) ? '0 : rd_ptr + 1'b1;
    end
  end

  // Registered RAM read port and status outputs
  always_ff @(posedge SYS_CLK or negedge RST) begin
    if (!RST) begin
      DATA_OUT         <= '0;
      DATA_OUT_VALID   <= 1'b0;
      PACKET_START_OUT <= 1'b0;
      PACKETS_STORED   <= '0;
      GOT_FULL_PACKET  <= 1'b0;
      OVERFLOW         <= 1'b0;
    end else begin
      if (rd_issue_c) DATA_OUT <= mem[rd_ptr][rd_off];
      DATA_OUT_VALID   <= rd_issue_c;
      PACKET_START_OUT <= rd_issue_c && (rd_off == '0);
      PACKETS_STORED   <= stored_nx;
      GOT_FULL_PACKET  <= (stored_nx != '0);
      OVERFLOW         <= drop_c;
    end
  end

endmodule
